// File: rtl/sseg_scan_capture.sv
// sseg_scan_capture: captures 4-digit multiplexed seven-segment scans back into hex frames.
// Define SSEG_CHANGE_ONLY_EN to pulse frame_valid_o only when the captured frame changes.
module sseg_scan_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  an_i,
  input  logic [6:0]  sseg_i,
  input  logic        dp_i,
  output logic [15:0] digits_o,
  output logic [3:0]  dps_o,
  output logic [3:0]  err_o,
  output logic        frame_valid_o,
  output logic        stale_o
);
  localparam int CW = $clog2(STABLE_CYCLES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_LATCHED} state_t;
  state_t state;
  logic [11:0] sync1, t, prev;
  logic [CW-1:0] stab_cnt, next_cnt;
  logic [TW-1:0] timeout_cnt;
  logic [15:0] sh_dig;
  logic [3:0] sh_dp, sh_err, seen, sel;
  logic [1:0] idx;
  logic [4:0] dec;
  logic valid, same, accept, done, upd;
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40: decode = 5'h00;
      7'h79: decode = 5'h01;
      7'h24: decode = 5'h02;
      7'h30: decode = 5'h03;
      7'h19: decode = 5'h04;
      7'h12: decode = 5'h05;
      7'h02: decode = 5'h06;
      7'h78: decode = 5'h07;
      7'h00: decode = 5'h08;
      7'h10: decode = 5'h09;
      7'h08: decode = 5'h0A;
      7'h03: decode = 5'h0B;
      7'h46: decode = 5'h0C;
      7'h21: decode = 5'h0D;
      7'h06: decode = 5'h0E;
      7'h0E: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction
  // next_cnt counts the current sample, so acceptance lands on the Nth identical one
  always_comb begin
    sel      = ~t[11:8];
    valid    = $onehot(sel);
    idx      = {sel[3] | sel[2], sel[3] | sel[1]};
    same     = t == prev;
    next_cnt = same ? stab_cnt + 1'b1 : CW'(1);
    accept   = state == S_SETTLE && valid && next_cnt >= CW'(STABLE_CYCLES);
    dec      = decode(t[7:1]);
  end
`ifdef SSEG_CHANGE_ONLY_EN
  logic first;
  always_comb upd = done && (first || {sh_dig, sh_dp, sh_err} != {digits_o, dps_o, err_o});
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) first <= 1'b1;
    else if (upd) first <= 1'b0;
`else
  always_comb upd = done;
`endif
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1         <= '1;
      t             <= '1;
      prev          <= '1;
      state         <= S_WAIT;
      stab_cnt      <= '0;
      timeout_cnt   <= '0;
      sh_dig        <= '0;
      sh_dp         <= '0;
      sh_err        <= '0;
      seen          <= '0;
      done          <= 1'b0;
      digits_o      <= '0;
      dps_o         <= '0;
      err_o         <= '0;
      frame_valid_o <= 1'b0;
      stale_o       <= 1'b0;
    end else begin
      sync1         <= {an_i, sseg_i, dp_i};
      t             <= sync1;
      prev          <= t;
      done          <= accept && (seen | sel) == 4'hF;
      frame_valid_o <= upd;
      case (state)
        S_WAIT: if (valid) begin
          state    <= S_SETTLE;
          stab_cnt <= CW'(1);
        end
        S_SETTLE: begin
          state    <= !valid ? S_WAIT : accept ? S_LATCHED : S_SETTLE;
          stab_cnt <= next_cnt;
        end
        S_LATCHED: if (!same) begin
          state    <= valid ? S_SETTLE : S_WAIT;
          stab_cnt <= CW'(1);
        end
        default: state <= S_WAIT;
      endcase
      if (accept) begin
        sh_dig[{idx, 2'b00} +: 4] <= dec[3:0];
        sh_dp[idx]                <= ~t[0];
        sh_err[idx]               <= dec[4];
        seen[idx]                 <= 1'b1;
        timeout_cnt               <= '0;
      end else if (timeout_cnt != TW'(TIMEOUT_CYCLES)) begin
        timeout_cnt <= timeout_cnt + 1'b1;
        if (timeout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          stale_o <= 1'b1;
          seen    <= '0;
        end
      end
      if (done) begin
        seen    <= '0;
        stale_o <= 1'b0;
      end
      if (upd) begin
        digits_o <= sh_dig;
        dps_o    <= sh_dp;
        err_o    <= sh_err;
      end
    end
  end
endmodule

// File: tb/tb_sseg_scan_capture.sv
// tb_sseg_scan_capture: directed scenarios for the seven-segment scan capture.
module tb_sseg_scan_capture;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [3:0]  an_i = 4'hF;
  logic [6:0]  sseg_i = 7'h7F;
  logic        dp_i = 1'b1;
  logic [15:0] digits_o;
  logic [3:0]  dps_o, err_o;
  logic        frame_valid_o, stale_o;
  int vectors = 0, miscompares = 0, pulses = 0, p = 0, exp_pulses = 0;

  sseg_scan_capture dut (
    .clk_i(clk_i), .rst_i(rst_i), .an_i(an_i), .sseg_i(sseg_i), .dp_i(dp_i),
    .digits_o(digits_o), .dps_o(dps_o), .err_o(err_o),
    .frame_valid_o(frame_valid_o), .stale_o(stale_o)
  );

  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) if (frame_valid_o) pulses++;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'h40; 4'h1: enc = 7'h79; 4'h2: enc = 7'h24; 4'h3: enc = 7'h30;
      4'h4: enc = 7'h19; 4'h5: enc = 7'h12; 4'h6: enc = 7'h02; 4'h7: enc = 7'h78;
      4'h8: enc = 7'h00; 4'h9: enc = 7'h10; 4'hA: enc = 7'h08; 4'hB: enc = 7'h03;
      4'hC: enc = 7'h46; 4'hD: enc = 7'h21; 4'hE: enc = 7'h06; default: enc = 7'h0E;
    endcase
  endfunction

  task automatic drive(input int k, input logic [6:0] s, input logic dpn, input int dwell);
    an_i = 4'hF;
    an_i[k] = 1'b0;
    sseg_i = s;
    dp_i = dpn;
    repeat (dwell) @(negedge clk_i);
  endtask

  task automatic scan(input logic [15:0] v, input logic [3:0] dp);
    for (int k = 0; k < 4; k++) drive(k, enc(v[4*k +: 4]), ~dp[k], 50);
  endtask

  task automatic test_reset;
    vectors++; if (digits_o !== 16'h0) begin miscompares++; $display("FAIL reset_digits: got %h expected %h", digits_o, 16'h0); end
    vectors++; if (dps_o !== 4'h0) begin miscompares++; $display("FAIL reset_dps: got %h expected %h", dps_o, 4'h0); end
    vectors++; if (err_o !== 4'h0) begin miscompares++; $display("FAIL reset_err: got %h expected %h", err_o, 4'h0); end
    vectors++; if (frame_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_fv: got %b expected 0", frame_valid_o); end
    vectors++; if (stale_o !== 1'b0) begin miscompares++; $display("FAIL reset_stale: got %b expected 0", stale_o); end
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_basic;
    p = pulses;
    scan(16'h1234, 4'h0);
    vectors++; if (pulses - p !== 1) begin miscompares++; $display("FAIL basic_pulse1: got %0d expected 1", pulses - p); end
    vectors++; if (digits_o !== 16'h1234) begin miscompares++; $display("FAIL basic_digits: got %h expected %h", digits_o, 16'h1234); end
    vectors++; if (dps_o !== 4'h0) begin miscompares++; $display("FAIL basic_dps: got %h expected %h", dps_o, 4'h0); end
    vectors++; if (err_o !== 4'h0) begin miscompares++; $display("FAIL basic_err: got %h expected %h", err_o, 4'h0); end
    scan(16'h1234, 4'h0);
    vectors++; if (pulses - p !== 2) begin miscompares++; $display("FAIL basic_pulse2: got %0d expected 2", pulses - p); end
  endtask

  task automatic test_errors;
    p = pulses;
    drive(0, enc(4'h9), 1'b0, 50);
    drive(1, 7'h7F, 1'b1, 50);
    drive(2, enc(4'hB), 1'b1, 50);
    drive(3, enc(4'hA), 1'b1, 50);
    vectors++; if (pulses - p !== 1) begin miscompares++; $display("FAIL err_pulse: got %0d expected 1", pulses - p); end
    vectors++; if (digits_o !== 16'hAB09) begin miscompares++; $display("FAIL err_digits: got %h expected %h", digits_o, 16'hAB09); end
    vectors++; if (err_o !== 4'b0010) begin miscompares++; $display("FAIL err_flags: got %b expected 0010", err_o); end
    vectors++; if (dps_o !== 4'b0001) begin miscompares++; $display("FAIL err_dps: got %b expected 0001", dps_o); end
  endtask

  // digit 3 from the glitched scan stays in its slot and completes the following frame
  task automatic test_glitch;
    p = pulses;
    drive(0, enc(4'h4), 1'b1, 50);
    drive(1, enc(4'h3), 1'b1, 50);
    drive(2, enc(4'h2), 1'b1, 3);
    drive(3, enc(4'h1), 1'b1, 50);
    vectors++; if (pulses - p !== 0) begin miscompares++; $display("FAIL glitch_nopulse: got %0d expected 0", pulses - p); end
    vectors++; if (digits_o !== 16'hAB09) begin miscompares++; $display("FAIL glitch_hold: got %h expected %h", digits_o, 16'hAB09); end
    scan(16'h4321, 4'h0);
    vectors++; if (pulses - p !== 1) begin miscompares++; $display("FAIL glitch_next_pulse: got %0d expected 1", pulses - p); end
    vectors++; if (digits_o !== 16'h1321) begin miscompares++; $display("FAIL glitch_next_digits: got %h expected %h", digits_o, 16'h1321); end
    vectors++; if (err_o !== 4'h0) begin miscompares++; $display("FAIL glitch_next_err: got %h expected %h", err_o, 4'h0); end
  endtask

  // digit 1 is accepted 6 edges after it is driven; stale follows 1024 edges later
  task automatic test_timeout;
    p = pulses;
    drive(0, enc(4'h7), 1'b1, 50);
    drive(1, enc(4'h6), 1'b1, 1029);
    vectors++; if (stale_o !== 1'b0) begin miscompares++; $display("FAIL stale_early: got %b expected 0", stale_o); end
    @(negedge clk_i);
    vectors++; if (stale_o !== 1'b1) begin miscompares++; $display("FAIL stale_edge: got %b expected 1", stale_o); end
    vectors++; if (digits_o !== 16'h1321) begin miscompares++; $display("FAIL stale_hold: got %h expected %h", digits_o, 16'h1321); end
    drive(2, enc(4'hE), 1'b1, 50);
    drive(3, enc(4'hF), 1'b1, 50);
    vectors++; if (pulses - p !== 0) begin miscompares++; $display("FAIL stale_discard: got %0d expected 0", pulses - p); end
    vectors++; if (stale_o !== 1'b1) begin miscompares++; $display("FAIL stale_sticky: got %b expected 1", stale_o); end
    drive(0, enc(4'hC), 1'b1, 50);
    drive(1, enc(4'hD), 1'b1, 50);
    vectors++; if (pulses - p !== 1) begin miscompares++; $display("FAIL stale_recover_pulse: got %0d expected 1", pulses - p); end
    vectors++; if (digits_o !== 16'hFEDC) begin miscompares++; $display("FAIL stale_recover_digits: got %h expected %h", digits_o, 16'hFEDC); end
    vectors++; if (stale_o !== 1'b0) begin miscompares++; $display("FAIL stale_clear: got %b expected 0", stale_o); end
  endtask

  task automatic test_change_only;
`ifdef SSEG_CHANGE_ONLY_EN
    exp_pulses = 2;
`else
    exp_pulses = 4;
`endif
    p = pulses;
    scan(16'h5678, 4'h0);
    vectors++; if (pulses - p !== 1) begin miscompares++; $display("FAIL change_first: got %0d expected 1", pulses - p); end
    scan(16'h5678, 4'h0);
    scan(16'h5678, 4'h0);
    scan(16'h5679, 4'h0);
    vectors++; if (pulses - p !== exp_pulses) begin miscompares++; $display("FAIL change_total: got %0d expected %0d", pulses - p, exp_pulses); end
    vectors++; if (digits_o !== 16'h5679) begin miscompares++; $display("FAIL change_digits: got %h expected %h", digits_o, 16'h5679); end
  endtask

  task automatic test_reset_mid;
    drive(0, enc(4'h1), 1'b1, 50);
    drive(1, enc(4'h2), 1'b1, 50);
    drive(2, enc(4'h3), 1'b1, 3);
    #1 rst_i = 1'b0;
    #1;
    vectors++; if (digits_o !== 16'h0) begin miscompares++; $display("FAIL midrst_digits: got %h expected %h", digits_o, 16'h0); end
    vectors++; if (stale_o !== 1'b0 || frame_valid_o !== 1'b0) begin miscompares++; $display("FAIL midrst_flags: got %b%b expected 00", stale_o, frame_valid_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    p = pulses;
    scan(16'hBEEF, 4'b1010);
    vectors++; if (pulses - p !== 1) begin miscompares++; $display("FAIL midrst_pulse: got %0d expected 1", pulses - p); end
    vectors++; if (digits_o !== 16'hBEEF) begin miscompares++; $display("FAIL midrst_digits_after: got %h expected %h", digits_o, 16'hBEEF); end
    vectors++; if (dps_o !== 4'b1010) begin miscompares++; $display("FAIL midrst_dps_after: got %b expected 1010", dps_o); end
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    test_reset;
    test_basic;
    test_errors;
    test_glitch;
    test_timeout;
    test_change_only;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
